// File: rtl/phasediff_avg.sv
// Multi-channel phase-difference averager: per-channel difference from
// channel 0, wrapped to [-pi, pi), averaged over 2^LOG2_AVG sample sets.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset
//   sample     phase set valid, taken only while busy=0
//   phase_in   packed signed phases, channel k at [k*W +: W]
//   busy       high while a set is being processed (state != IDLE)
//   out        packed averaged differences, channel k at [(k-1)*W +: W]
//   out_valid  one-cycle pulse when out is updated
//   overrun    sticky flag, sample seen while busy
module phasediff_avg #(
  parameter int W        = 19,
  parameter int FRAC     = 10,
  parameter int NCH      = 4,
  parameter int LOG2_AVG = 3,
  parameter int PI_Q     = 3217
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample,
  input  logic [NCH*W-1:0]       phase_in,
  output logic                   busy,
  output logic [(NCH-1)*W-1:0]   out,
  output logic                   out_valid,
  output logic                   overrun
);

  if (NCH < 2 || FRAC >= W - 1) begin : g_bad_cfg
    $error("phasediff_avg: NCH must be >= 2 and FRAC < W-1");
  end

  localparam int AW   = W + LOG2_AVG;
  localparam int IW   = $clog2(NCH);
  localparam int SW   = LOG2_AVG + 1;
  localparam int SETS = 1 << LOG2_AVG;

  localparam logic signed [W:0] PI_P = (W+1)'(PI_Q);
  localparam logic signed [W:0] PI_N = -PI_P;
  localparam logic signed [W:0] TWO  = (W+1)'(2 * PI_Q);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DUMP
  } state_t;

  state_t state, nstate;

  logic [W-1:0]           ph  [NCH];
  logic signed [AW-1:0]   acc [1:NCH-1];
  logic [IW-1:0]          ch;
  logic [SW-1:0]          cnt;

  logic signed [W:0]      pk, p0, d_raw, d_wrap;
  logic signed [AW-1:0]   d_ext;
  logic                   last_ch, last_set;

  assign busy     = (state != IDLE);
  assign last_ch  = (ch == IW'(NCH - 1));
  assign last_set = (cnt == SW'(SETS - 1));

  // Difference at W+1 bits so the raw value cannot overflow before wrap.
  always_comb begin
    pk     = {ph[ch][W-1], ph[ch]};
    p0     = {ph[0][W-1], ph[0]};
    d_raw  = pk - p0;
    d_wrap = d_raw;
    if (d_raw >= PI_P)
      d_wrap = d_raw - TWO;
    else if (d_raw < PI_N)
      d_wrap = d_raw + TWO;
    d_ext  = AW'(d_wrap);
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (sample) nstate = CALC;
      CALC: if (last_ch) nstate = last_set ? DUMP : IDLE;
      DUMP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nstate;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ch        <= IW'(1);
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NCH; k++)
        ph[k] <= '0;
      for (int k = 1; k < NCH; k++)
        acc[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample && busy)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (sample) begin
            for (int k = 0; k < NCH; k++)
              ph[k] <= phase_in[k*W +: W];
            ch <= IW'(1);
          end
        end
        CALC: begin
          acc[ch] <= acc[ch] + d_ext;
          ch      <= ch + IW'(1);
          if (last_ch)
            cnt <= last_set ? '0 : cnt + SW'(1);
        end
        DUMP: begin
          // Arithmetic shift gives floor rounding of the mean.
          for (int k = 1; k < NCH; k++) begin
            out[(k-1)*W +: W] <= W'(acc[k] >>> LOG2_AVG);
            acc[k]            <= '0;
          end
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phasediff_avg.sv
// Directed self-checking bench for phasediff_avg.
// Two instances: no averaging (LOG2_AVG=0) and 8-set averaging.
module tb_phasediff_avg;

  localparam int W   = 19;
  localparam int NCH = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 sample;
  logic [NCH*W-1:0]     phase_in;

  logic                 busy0, ov0, orun0;
  logic [(NCH-1)*W-1:0] out0;
  logic                 busy3, ov3, orun3;
  logic [(NCH-1)*W-1:0] out3;

  int errors = 0;
  int checks = 0;

  phasediff_avg #(.W(W), .NCH(NCH), .LOG2_AVG(0)) dut0 (
    .clock(clock), .reset(reset), .sample(sample),
    .phase_in(phase_in), .busy(busy0), .out(out0),
    .out_valid(ov0), .overrun(orun0)
  );

  phasediff_avg #(.W(W), .NCH(NCH), .LOG2_AVG(3)) dut3 (
    .clock(clock), .reset(reset), .sample(sample),
    .phase_in(phase_in), .busy(busy3), .out(out3),
    .out_valid(ov3), .overrun(orun3)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f0(input int k);
    logic signed [W-1:0] v;
    v = out0[(k-1)*W +: W];
    return int'(v);
  endfunction

  function automatic int f3(input int k);
    logic signed [W-1:0] v;
    v = out3[(k-1)*W +: W];
    return int'(v);
  endfunction

  task automatic drive(input int p0, input int p1,
                       input int p2, input int p3);
    phase_in = {W'(p3), W'(p2), W'(p1), W'(p0)};
  endtask

  // Accept one set, then run to cycle 4 after acceptance.
  task automatic send(input int p0, input int p1,
                      input int p2, input int p3);
    drive(p0, p1, p2, p3);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset  = 1'b0;
    sample = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_busy0", busy0, 0);
    chk("rst_ov0", ov0, 0);
    chk("rst_orun0", orun0, 0);
    chk("rst_out0", int'(|out0), 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_out3", int'(|out3), 0);
    reset = 1'b1;
    tick();

    // Basic difference, no averaging.
    drive(0, 1024, -1024, 3000);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    chk("basic_busy_c1", busy0, 1);
    tick();
    tick();
    chk("basic_busy_c3", busy0, 1);
    tick();
    chk("basic_busy_c4", busy0, 1);
    chk("basic_ov_c4", ov0, 0);
    tick();
    chk("basic_ov_c5", ov0, 1);
    chk("basic_busy_c5", busy0, 0);
    chk("basic_ch1", f0(1), 1024);
    chk("basic_ch2", f0(2), -1024);
    chk("basic_ch3", f0(3), 3000);
    tick();
    chk("basic_ov_c6", ov0, 0);
    chk("basic_hold", f0(1), 1024);

    // Wrap cases.
    send(-3000, 3000, -3000, 0);
    tick();
    chk("wpos_ov", ov0, 1);
    chk("wpos_ch1", f0(1), -434);
    chk("wpos_ch2", f0(2), 0);
    chk("wpos_ch3", f0(3), 3000);

    send(3000, -3000, 0, -3217);
    tick();
    chk("wneg_ch1", f0(1), 434);
    chk("wneg_ch2", f0(2), -3000);
    chk("wneg_ch3", f0(3), 217);

    send(0, -3217, 3216, 0);
    tick();
    chk("edge_ch1", f0(1), -3217);
    chk("edge_ch2", f0(2), 3216);
    chk("edge_ch3", f0(3), 0);

    send(-1, 3216, -3217, -1);
    tick();
    chk("pi_ch1", f0(1), -3217);
    chk("pi_ch2", f0(2), -3216);
    chk("pi_ch3", f0(3), 0);

    // Fresh start for the averaging instance.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_busy3", busy3, 0);
    chk("rst2_ov3", ov3, 0);
    chk("rst2_out3", int'(|out3), 0);

    // Block A: ch1 100/101 alternating, ch2 seven -1 and one 0.
    for (int i = 0; i < 8; i++) begin
      send(500, (i % 2 == 1) ? 601 : 600,
           (i == 7) ? 500 : 499, 2500);
      if (i < 7) begin
        chk("avgA_busy_mid", busy3, 0);
        chk("avgA_ov_mid", ov3, 0);
      end else begin
        chk("avgA_busy_dump", busy3, 1);
        chk("avgA_ov_dump", ov3, 0);
      end
    end
    tick();
    chk("avgA_ov", ov3, 1);
    chk("avgA_ch1", f3(1), 100);
    chk("avgA_ch2", f3(2), -1);
    chk("avgA_ch3", f3(3), 2000);

    // Block B starts in the out_valid cycle.
    for (int i = 0; i < 8; i++) begin
      send(-200, 100, -3200, -250);
      if (i < 7)
        chk("avgB_ov_mid", ov3, 0);
      if (i == 0)
        chk("avgB_hold", f3(1), 100);
    end
    tick();
    chk("avgB_ov", ov3, 1);
    chk("avgB_ch1", f3(1), 300);
    chk("avgB_ch2", f3(2), -3000);
    chk("avgB_ch3", f3(3), -50);
    tick();
    chk("avgB_no_extra", ov3, 0);
    chk("pre_orun", orun3, 0);

    // Overrun: sample held high, garbage between accept points.
    for (int s = 0; s < 8; s++) begin
      drive(100, 140, 100, -100);
      sample = 1'b1;
      chk("ovr_idle", busy3, 0);
      tick();
      if (s == 0)
        chk("ovr_first_c1", orun3, 0);
      drive(-3000, 3000, 2000, -2000);
      tick();
      chk("ovr_sticky", orun3, 1);
      tick();
      tick();
      if (s == 7)
        tick();
    end
    chk("ovr_ov", ov3, 1);
    chk("ovr_ch1", f3(1), 40);
    chk("ovr_ch2", f3(2), 0);
    chk("ovr_ch3", f3(3), -200);
    sample = 1'b0;

    // Reset in the middle of the sixth set.
    for (int i = 0; i < 5; i++)
      send(0, 700, 0, 0);
    drive(0, 700, 0, 0);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_busy", busy3, 0);
    chk("mid_out", int'(|out3), 0);
    chk("mid_orun", orun3, 0);
    chk("mid_ov", ov3, 0);

    for (int i = 0; i < 8; i++) begin
      send(10, 210, 10, 10);
      if (i < 7)
        chk("fresh_ov_mid", ov3, 0);
    end
    tick();
    chk("fresh_ov", ov3, 1);
    chk("fresh_ch1", f3(1), 200);
    chk("fresh_ch2", f3(2), 0);
    chk("fresh_ch3", f3(3), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phasediff_avg.md
Name: phasediff_avg

Overview:
- Multi-channel successor to the two-input phase-difference block in the HilbertFilter receive chain.
- Takes one phase word per receiver channel and computes each channel's difference from reference channel 0.
- Wraps each difference into [-pi, pi) and averages it over 2^LOG2_AVG sample sets.
- Feeds the direction-estimation stage with one averaged, wrapped difference per non-reference channel.

Parameters:
W, 19, phase word width, signed fixed point
FRAC, 10, fractional bits (1.0 rad = 1024)
NCH, 4, channel count including reference channel 0 (>= 2)
LOG2_AVG, 3, log2 of sample sets per average (0 = no averaging)
PI_Q, 3217, round(pi * 2^FRAC); TWO_PI_Q = 2*PI_Q = 6434

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
sample  in  1  phase set valid; accepted only when busy=0
phase_in  in  NCH*W  packed signed phases, channel k at bits [k*W +: W]
busy  out  1  high whenever state != IDLE
out  out  (NCH-1)*W  packed averaged differences, channel k (1..NCH-1) at [(k-1)*W +: W]
out_valid  out  1  one-cycle pulse, out updated
overrun  out  1  sticky; sample asserted while busy=1

Behaviour:
- Reset (reset=0 at edge): state=IDLE, busy=0, out=0, out_valid=0, overrun=0, all accumulators=0, set counter=0. Takes priority over every other event, including mid-CALC or mid-DUMP; a partial block is discarded.
- FSM states are IDLE, CALC and DUMP.
- IDLE:
  - sample=1 latches all of phase_in, clears the channel index to 1 and moves to CALC.
  - sample=0 stays in IDLE.
- CALC, one cycle per channel k = 1..NCH-1:
  - d = phase_k - phase_0, computed at W+1 bits.
  - If d >= PI_Q, d -= TWO_PI_Q. Else if d < -PI_Q, d += TWO_PI_Q.
  - Exactly one correction is applied. Inputs are defined to lie in [-PI_Q, PI_Q), so the result is in [-PI_Q, PI_Q).
  - acc[k] += d. acc is W+LOG2_AVG bits signed and cannot overflow.
  - After channel NCH-1, the set counter increments. If it reaches 2^LOG2_AVG, go to DUMP and wrap the counter to 0; otherwise go to IDLE.
- DUMP, one cycle:
  - out[k] <= acc[k] >>> LOG2_AVG (arithmetic shift, floor rounding).
  - acc[k] <= 0 and out_valid <= 1, then go to IDLE.
  - out_valid is therefore high in the first IDLE cycle after DUMP and low otherwise. out holds until the next DUMP.
- Latency with NCH=4: sample accepted in cycle 0, CALC in cycles 1-3.
  - Non-final set: IDLE in cycle 4.
  - Final set: DUMP in cycle 4, out/out_valid visible in cycle 5.
  - Throughput is one set per NCH cycles, or NCH+1 cycles for the block-final set.
- sample=1 in CALC or DUMP: input ignored, no data change, overrun <= 1. overrun clears only on reset.
- sample=1 in the IDLE cycle where out_valid=1 is accepted normally.
- The latched phases are held through CALC; phase_in changing during busy has no effect.
- Averaging is linear on wrapped values. Differences straddling ±pi within one block average incorrectly; this is a known limitation, handled upstream by calibration.

Test Plan:
- Basic diff, LOG2_AVG=0, NCH=4: ch0=0, ch1=1024, ch2=-1024, ch3=3000, sample one cycle -> out_valid in cycle 5; out = {3000, -1024, 1024} (ch3, ch2, ch1); busy high cycles 1-4.
- Positive wrap: ch0=-3000, ch1=3000 -> d=6000 -> ch1 out = -434. Negative wrap: ch0=3000, ch1=-3000 -> ch1 out = 434. Edge case: ch0=0, ch1=-3217 -> -3217 unchanged.
- Averaging, LOG2_AVG=3: 8 sets with ch1-ch0 alternating 100/101 -> single out_valid after 8th set, ch1 out = 100. Seven sets of -1 plus one of 0 -> out = -1 (floor); no out_valid before set 8.
- Overrun: sample held high continuously -> accepted only on IDLE cycles (every 4th cycle; 5th at block end); overrun=1 from the first ignored cycle; data equals the accepted sets only.
- Reset mid-operation: reset=0 in cycle 2 of CALC after 5 of 8 sets -> next cycle busy=0, out=0, overrun=0. Then 8 fresh sets of ch1 diff 200 -> out = 200, with no contribution from the pre-reset sets.
- Back-to-back blocks: sample asserted in the out_valid cycle -> accepted; second block's average correct; no extra out_valid pulse.
